// File: rtl/mips_pkg.sv
// Shared datapath definitions: operand width, sequencer state encoding and the
// carry-out reconstruction used around the carry-less ripple adder.
package mips_pkg;

    localparam int WIDTH_W = 32;
    localparam int CNT_W   = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The adder exposes no carry-out, so recover it from the operand and sum MSBs.
    function automatic logic carry_out(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb & b_msb) | ((a_msb ^ b_msb) & ~s_msb);
    endfunction

endpackage

// File: rtl/thirtyTwoBitsFullAdder.sv
// 32-bit ripple-carry adder shared with the ALU; sum only, no carry-out port.
module thirtyTwoBitsFullAdder
    import mips_pkg::*;
(
    input  logic [WIDTH_W-1:0] a,
    input  logic [WIDTH_W-1:0] b,
    input  logic               c0,
    output logic [WIDTH_W-1:0] s
);

    logic [WIDTH_W-1:0] c;

    assign c[0] = c0;

    for (genvar i = 0; i < WIDTH_W; i++) begin : g_bit
        assign s[i] = a[i] ^ b[i] ^ c[i];
        if (i < WIDTH_W - 1) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/adder_mult_sequencer.sv
// Multi-cycle unsigned multiplier: runs the shared ripple adder through one
// shift-and-add step per cycle and returns a {hi,lo} product for MULTU.
//
// state   | meaning
// IDLE    | waiting for start; operands captured on accept
// ITER    | one shift-and-add step per cycle, 32 steps
// DONE    | done pulse; product register already holds the result
module adder_mult_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH      = WIDTH_W,
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;

    assign addend = q_q[0] ? m_q : '0;

    thirtyTwoBitsFullAdder u_adder (
        .a  (acc_q),
        .b  (addend),
        .c0 (1'b0),
        .s  (sum)
    );

    assign cout = carry_out(acc_q[WIDTH-1], addend[WIDTH-1], sum[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    acc_d   = '0;
                    q_d     = multiplier;
                    count_d = '0;
                    if (EARLY_ZERO && ((multiplicand == '0) || (multiplier == '0))) begin
                        state_d   = ST_DONE;
                        product_d = '0;
                    end else begin
                        state_d = ST_ITER;
                    end
                end
            end
            ST_ITER: begin
                // {cout, sum, Q} shifted right by one
                acc_d = {cout, sum[WIDTH-1:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                if (count_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    product_d = {cout, sum, q_q[WIDTH-1:1]};
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_adder_mult_sequencer.sv
// Self-checking bench for adder_mult_sequencer: directed scenarios plus random
// operands, checked against plain 64-bit multiplication and the stated latency.
module tb_adder_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst;

    logic        start1, start0;
    logic [31:0] a1, b1, a0, b0;
    logic        busy1, done1, busy0, done0;
    logic [63:0] product1, product0;

    int checks   = 0;
    int failures = 0;
    bit sel_ez0  = 1'b0;

    always #5 clk = ~clk;

    adder_mult_sequencer #(.WIDTH(32), .EARLY_ZERO(1'b1)) dut_ez1 (
        .clk(clk), .rst(rst), .start(start1), .multiplicand(a1), .multiplier(b1),
        .busy(busy1), .done(done1), .product(product1)
    );

    adder_mult_sequencer #(.WIDTH(32), .EARLY_ZERO(1'b0)) dut_ez0 (
        .clk(clk), .rst(rst), .start(start0), .multiplicand(a0), .multiplier(b0),
        .busy(busy0), .done(done0), .product(product0)
    );

    logic        busy_s, done_s;
    logic [63:0] product_s;
    assign busy_s    = sel_ez0 ? busy0    : busy1;
    assign done_s    = sel_ez0 ? done0    : done1;
    assign product_s = sel_ez0 ? product0 : product1;

    task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b);
        if (sel_ez0) begin
            start0 = s; a0 = a; b0 = b;
        end else begin
            start1 = s; a1 = a; b1 = b;
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wa, wb;
        wa = {32'd0, a};
        wb = {32'd0, b};
        return wa * wb;
    endfunction

    function automatic int ref_lat(input bit ez0, input logic [31:0] a, input logic [31:0] b);
        if (!ez0 && (a == 0 || b == 0)) return 1;
        return 33;
    endfunction

    // One operation: start at a negedge, then observe 40 cycles. inject_k > 0
    // pulses a second start (ia x ib) at that cycle, which must be ignored.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input int inject_k, input logic [31:0] ia, input logic [31:0] ib);
        logic [63:0] exp_p;
        int exp_lat, first_done, pulses, busy_cycles;
        logic [63:0] p_at_done;
        exp_p      = ref_mul(a, b);
        exp_lat    = ref_lat(sel_ez0, a, b);
        first_done = -1;
        pulses     = 0;
        busy_cycles = 0;
        p_at_done  = '0;
        @(negedge clk);
        drive(1'b1, a, b);
        @(negedge clk);
        drive(1'b0, $urandom, $urandom);
        for (int k = 1; k <= 40; k++) begin
            if (done_s) begin
                pulses++;
                if (first_done < 0) begin
                    first_done = k;
                    p_at_done  = product_s;
                end
            end
            if (busy_s) busy_cycles++;
            if (inject_k > 0 && k == inject_k) drive(1'b1, ia, ib);
            if (inject_k > 0 && k == inject_k + 1) drive(1'b0, ia, ib);
            if (k < 40) @(negedge clk);
        end
        checks++;
        if (first_done !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, first_done, exp_lat);
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, pulses);
        end
        checks++;
        if (p_at_done !== exp_p) begin
            failures++;
            $display("FAIL %s product: got %h expected %h", name, p_at_done, exp_p);
        end
        checks++;
        if (busy_cycles !== exp_lat) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cycles, exp_lat);
        end
        checks++;
        if (product_s !== exp_p) begin
            failures++;
            $display("FAIL %s product_hold: got %h expected %h", name, product_s, exp_p);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start1 = 1'b0; a1 = '0; b1 = '0;
        start0 = 1'b0; a0 = '0; b0 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy1, done1, product1, busy0, done0, product0} !== '0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b%b done=%b%b p1=%h p0=%h expected all zero",
                     busy1, busy0, done1, done0, product1, product0);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy1, done1, busy0, done0} !== 4'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b%b done=%b%b expected 0",
                     busy1, busy0, done1, done0);
        end
    endtask

    task automatic test_directed;
        sel_ez0 = 1'b0;
        run_op("3x4", 32'd3, 32'd4, 0, 0, 0);
        run_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        checks++;
        if (product1 !== 64'hFFFF_FFFE_0000_0001) begin
            failures++;
            $display("FAIL ffxff_const: got %h expected FFFFFFFE00000001", product1);
        end
        run_op("0x987654_ez1", 32'd0, 32'd987654, 0, 0, 0);
        run_op("987654x0_ez1", 32'd987654, 32'd0, 0, 0, 0);
        sel_ez0 = 1'b1;
        run_op("0x987654_ez0", 32'd0, 32'd987654, 0, 0, 0);
        sel_ez0 = 1'b0;
        run_op("1x1", 32'd1, 32'd1, 0, 0, 0);
    endtask

    task automatic test_ignored_start;
        sel_ez0 = 1'b0;
        run_op("busy_start", 32'd345678, 32'd987654, 10, 32'd5, 32'd1);
    endtask

    task automatic test_reset_abort;
        int pulses;
        sel_ez0 = 1'b0;
        pulses  = 0;
        @(negedge clk);
        drive(1'b1, 32'd1092657, 32'd1534);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy1, done1, product1} !== '0) begin
            failures++;
            $display("FAIL reset_abort_state: got busy=%b done=%b product=%h expected 0",
                     busy1, done1, product1);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done1 || busy1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL reset_abort_quiet: got %0d active cycles expected 0", pulses);
        end
        run_op("12x10", 32'd12, 32'd10, 0, 0, 0);
    endtask

    task automatic test_back_to_back;
        int d_k[$];
        logic [63:0] d_p[$];
        sel_ez0 = 1'b0;
        @(negedge clk);
        drive(1'b1, 32'd15, 32'd15);
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (done1) begin
                d_k.push_back(k);
                d_p.push_back(product1);
                if (d_k.size() == 1) drive(1'b1, 32'd9, 32'd9);
                else drive(1'b0, 32'd0, 32'd0);
            end
        end
        drive(1'b0, 32'd0, 32'd0);
        checks++;
        if (d_k.size() !== 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d done pulses expected 2", d_k.size());
        end else begin
            checks++;
            if (d_k[1] - d_k[0] !== 34) begin
                failures++;
                $display("FAIL b2b_period: got %0d expected 34", d_k[1] - d_k[0]);
            end
            checks++;
            if (d_p[0] !== ref_mul(15, 15) || d_p[1] !== ref_mul(9, 9)) begin
                failures++;
                $display("FAIL b2b_products: got %0d,%0d expected 225,81", d_p[0], d_p[1]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 5 == 2) a = '0;
            if (i % 5 == 4) b = '0;
            if (i % 4 == 1) a = a >> $urandom_range(31, 0);
            sel_ez0 = (i % 3 == 0);
            run_op($sformatf("rand%0d", i), a, b, 0, 0, 0);
        end
        sel_ez0 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ignored_start;
        test_reset_abort;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
